spi_burst_ctrl: RTL and testbench
=================================

SPI_BURST_CTRL -- requirements
Module: spi_burst_ctrl

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, giving the SPI word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, giving the entries per FIFO; it SHALL be a power of two and at least 2.
REQ-003 clk  in  1  system clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-low.
REQ-005 tx_valid  in  1  host offers tx_data.
REQ-006 tx_ready  out  1  TX FIFO not full.
REQ-007 tx_data  in  DWIDTH  byte to send.
REQ-008 rx_valid  out  1  RX FIFO not empty.
REQ-009 rx_ready  in  1  host accepts rx_data.
REQ-010 rx_data  out  DWIDTH  head of the RX FIFO (first-word fall-through).
REQ-011 core_cs, core_wr, core_rd  out  1 each  command strobes to spi_core.
REQ-012 core_din  out  DWIDTH  write data to spi_core.
REQ-013 core_dout  in  DWIDTH  read data from spi_core.
REQ-014 core_done  in  1  spi_core idle or transfer complete.
REQ-015 busy  out  1  FSM not in IDLE, or TX FIFO not empty.

Function
REQ-016 A TX push SHALL occur on any cycle where tx_valid and tx_ready are both high; an RX pop SHALL occur on any cycle where rx_valid and rx_ready are both high.
REQ-017 On a simultaneous push and pop to the same FIFO, the count SHALL be unchanged and both operations SHALL take effect.
REQ-018 The FIFO pointers SHALL wrap modulo DEPTH; the full and empty flags SHALL be derived from a count register that is clog2(DEPTH)+1 bits wide.
REQ-019 The FSM states SHALL be IDLE, START, WAIT_BUSY, WAIT_DONE and CAPTURE.
REQ-020 The FSM SHALL move from IDLE to START only when the TX FIFO is non-empty, core_done=1, and RX count + 1 <= DEPTH, so that no transfer begins without a free RX slot.
REQ-021 In START, core_cs=1, core_wr=1 and core_din=TX head for exactly one cycle; the TX FIFO SHALL pop in that same cycle; the next state SHALL be WAIT_BUSY.
REQ-022 WAIT_BUSY SHALL move to WAIT_DONE when core_done=0.
REQ-023 WAIT_DONE SHALL move to CAPTURE when core_done=1.
REQ-024 In CAPTURE, core_cs=1 and core_rd=1 for one cycle, and core_dout SHALL be pushed into the RX FIFO on that same edge; the next state SHALL be IDLE.
REQ-025 core_rd and core_wr SHALL never be high in the same cycle; outside START and CAPTURE, core_cs, core_wr and core_rd SHALL all be 0.
REQ-026 Latency SHALL be 2 cycles from a tx push into an empty, idle block to core_wr=1, and 1 cycle from core_done rising in WAIT_DONE to rx_valid=1 (when the RX FIFO was empty).
REQ-027 Back-to-back transfers SHALL re-enter START no earlier than 1 cycle after CAPTURE.
REQ-028 Pushes while full and pops while empty SHALL be ignored, with no state change.
REQ-029 core_din SHALL equal the TX head combinationally; its value SHALL be a don't-care outside START.

Reset
REQ-030 Assertion of rst SHALL immediately force: FSM=IDLE; both FIFO counts and pointers=0; core_cs, core_wr, core_rd=0; tx_ready=1; rx_valid=0; busy=0.
REQ-031 FIFO storage SHALL NOT require reset; rx_data SHALL be a don't-care while rx_valid=0.
REQ-032 Reset asserted mid-transfer SHALL discard in-flight and queued data; spi_core SHALL be reset by the same rst at system level.

Structure
REQ-033 Package spi_pkg SHALL hold the FSM state enumeration and the default DWIDTH and DEPTH constants.
REQ-034 A sub-module spi_fifo (synchronous, first-word fall-through, parameters DWIDTH and DEPTH) SHALL be instantiated twice, once for TX and once for RX.

Verification
REQ-035 Single byte: push 0xAA and model the spi_core loopback -> exactly one core_wr pulse with core_din=0xAA, then rx_data=expected shifted byte with rx_valid=1.
REQ-036 Burst: push 0x01, 0x02, 0x03, 0x04 back-to-back -> tx_ready=0 after the 4th push if no transfer has started; 4 core_wr pulses occur in order, and 4 RX words emerge in order.
REQ-037 RX backpressure: hold rx_ready=0 and push 5 bytes -> exactly 4 transfers occur and the 5th waits in IDLE; a single pop releases it.
REQ-038 Simultaneous push and pop while the TX count is 2 -> the count remains 2 and data order is preserved.
REQ-039 Assert rst during WAIT_DONE -> all outputs take their REQ-030 values in the same cycle; after release, a push of 0x55 completes normally.
REQ-040 An assertion checker SHALL run throughout all scenarios and flag any cycle with core_rd and core_wr both high, or with a core strobe high outside START or CAPTURE.

Source files
------------

// File: rtl/spi_burst_ctrl_pkg.sv
// Shared definitions for the SPI burst controller slice.
//   - Default word width and FIFO depth used by the interface, FIFO and top.
//   - FSM state encoding, kept as plain sized constants so that the state
//     register is an ordinary logic vector in every tool.
package spi_pkg;

    localparam int DEF_DWIDTH = 8;
    localparam int DEF_DEPTH  = 4;

    typedef logic [2:0] state_t;

    localparam state_t IDLE      = 3'd0;
    localparam state_t START     = 3'd1;
    localparam state_t WAIT_BUSY = 3'd2;
    localparam state_t WAIT_DONE = 3'd3;
    localparam state_t CAPTURE   = 3'd4;

endpackage

// File: rtl/spi_burst_ctrl_if.sv
// Host-side streaming interface of the SPI burst controller.
//   tx_valid/tx_ready/tx_data : host -> controller byte stream (TX FIFO push)
//   rx_valid/rx_ready/rx_data : controller -> host byte stream (RX FIFO pop)
// modport master : host side (drives tx_valid, tx_data, rx_ready)
// modport slave  : controller side (drives tx_ready, rx_valid, rx_data)
interface spi_burst_ctrl_if
    import spi_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH
);

    logic              tx_valid;
    logic              tx_ready;
    logic [DWIDTH-1:0] tx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [DWIDTH-1:0] rx_data;

    modport master (
        output tx_valid, tx_data, rx_ready,
        input  tx_ready, rx_valid, rx_data
    );

    modport slave (
        input  tx_valid, tx_data, rx_ready,
        output tx_ready, rx_valid, rx_data
    );

endinterface

// File: rtl/spi_burst_ctrl_fifo.sv
// spi_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst (async, active-low) : clock / reset of pointers and count
//   push, wr_data                : write request and data (ignored when full)
//   pop                          : read request (ignored when empty)
//   rd_data                      : current head, valid whenever empty=0
//   full, empty                  : occupancy flags derived from the count
// DEPTH must be a power of two and at least 2; the pointers rely on natural
// binary wrap. Storage is not reset, only the control state is.
module spi_fifo
    import spi_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              pop,
    output logic [DWIDTH-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        // A simultaneous push and pop leaves the count where it is.
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/spi_burst_ctrl.sv
// spi_burst_ctrl: queues host bytes, issues one spi_core write per byte,
// waits for the core to finish and captures the received word.
//   clk, rst (async, active-low)  : system clock / reset
//   host (spi_burst_ctrl_if.slave): TX/RX byte streams to the host
//   core_cs, core_wr, core_rd     : single-cycle command strobes to spi_core
//   core_din / core_dout          : write data to / read data from spi_core
//   core_done                     : spi_core idle or transfer complete
//   busy                          : FSM active or bytes still queued
module spi_burst_ctrl
    import spi_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    spi_burst_ctrl_if.slave   host,
    output logic              core_cs,
    output logic              core_wr,
    output logic              core_rd,
    output logic [DWIDTH-1:0] core_din,
    input  logic [DWIDTH-1:0] core_dout,
    input  logic              core_done,
    output logic              busy
);

    state_t            state_q, state_d;
    logic [DWIDTH-1:0] tx_head;
    logic              tx_full, tx_empty;
    logic              rx_full, rx_empty;
    logic              tx_pop;
    logic              rx_push;

    spi_fifo #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (host.tx_valid),
        .wr_data (host.tx_data),
        .pop     (tx_pop),
        .rd_data (tx_head),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    spi_fifo #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (rx_push),
        .wr_data (core_dout),
        .pop     (host.rx_ready),
        .rd_data (host.rx_data),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    assign host.tx_ready = !tx_full;
    assign host.rx_valid = !rx_empty;

    // Only one transfer is ever in flight, so a non-full RX FIFO at the
    // start guarantees a slot for the word captured at the end.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (!tx_empty && core_done && !rx_full) state_d = START;
            START:     state_d = WAIT_BUSY;
            WAIT_BUSY: if (!core_done) state_d = WAIT_DONE;
            WAIT_DONE: if (core_done) state_d = CAPTURE;
            CAPTURE:   state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobes decode straight from the state register so they are glitch-free
    // single-cycle pulses that vanish as soon as reset asserts.
    assign core_wr  = (state_q == START);
    assign core_rd  = (state_q == CAPTURE);
    assign core_cs  = core_wr || core_rd;
    assign core_din = tx_head;
    assign tx_pop   = core_wr;
    assign rx_push  = core_rd;
    assign busy     = (state_q != IDLE) || !tx_empty;

endmodule

// File: tb/tb_spi_burst_ctrl.sv
module tb_spi_burst_ctrl;
    import spi_pkg::*;

    localparam int DW = 8;
    localparam int DP = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spi_burst_ctrl_if #(.DWIDTH(DW)) host_if ();

    logic          core_cs, core_wr, core_rd, core_done, busy;
    logic [DW-1:0] core_din;
    logic [DW-1:0] core_dout;

    spi_burst_ctrl #(.DWIDTH(DW), .DEPTH(DP)) dut (
        .clk       (clk),
        .rst       (rst),
        .host      (host_if),
        .core_cs   (core_cs),
        .core_wr   (core_wr),
        .core_rd   (core_rd),
        .core_din  (core_din),
        .core_dout (core_dout),
        .core_done (core_done),
        .busy      (busy)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string msg);
        vectors++;
        miscompares++;
        $display("FAIL %s: %s", name, msg);
    endtask

    // The spi_core loopback returns the written byte rotated left by one.
    function automatic logic [DW-1:0] rotl(input logic [DW-1:0] d);
        return {d[DW-2:0], d[DW-1]};
    endfunction

    // ---------------- spi_core behavioural model ----------------
    logic          core_hold = 1'b0;   // forces core_done low to stall the FSM
    logic          done_q;
    int            cnt_q;
    logic [DW-1:0] sh_q;

    assign core_done = done_q && !core_hold;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q    <= 1'b1;
            cnt_q     <= 0;
            sh_q      <= '0;
            core_dout <= '0;
        end else if (core_cs && core_wr) begin
            done_q <= 1'b0;
            cnt_q  <= 3;
            sh_q   <= core_din;
        end else if (cnt_q > 0) begin
            cnt_q <= cnt_q - 1;
            if (cnt_q == 1) begin
                done_q    <= 1'b1;
                core_dout <= rotl(sh_q);
            end
        end
    end

    // ---------------- scoreboard and strobe checker ----------------
    logic [DW-1:0] wr_q[$];
    logic [DW-1:0] rx_q[$];
    int            wr_pulses = 0;
    logic          prev_wr   = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            vectors++;
            assert (!(core_rd && core_wr)
                    && ({core_cs, core_wr, core_rd} inside {3'b000, 3'b110, 3'b101})
                    && !(prev_wr && core_wr))
            else begin
                miscompares++;
                $display("FAIL strobe_protocol: cs=%0b wr=%0b rd=%0b prev_wr=%0b",
                         core_cs, core_wr, core_rd, prev_wr);
            end
            if (core_cs && core_wr) begin
                wr_pulses++;
                if (wr_q.size() == 0) fail("core_din", "write pulse with no queued byte");
                else check("core_din", core_din, wr_q.pop_front());
            end
            if (host_if.rx_valid && host_if.rx_ready) begin
                if (rx_q.size() == 0) fail("rx_data", "rx word with no expected value");
                else check("rx_data", host_if.rx_data, rx_q.pop_front());
            end
            if (host_if.tx_valid && host_if.tx_ready) begin
                wr_q.push_back(host_if.tx_data);
                rx_q.push_back(rotl(host_if.tx_data));
            end
        end
        prev_wr = core_wr && rst;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        host_if.tx_valid = 1'b1;
        host_if.tx_data  = d;
        tick();
        host_if.tx_valid = 1'b0;
    endtask

    task automatic push_wait(input logic [DW-1:0] d);
        int n = 0;
        while (!host_if.tx_ready && n < 100) begin
            tick();
            n++;
        end
        check("push_wait_ready", host_if.tx_ready, 1);
        push(d);
    endtask

    task automatic pop1();
        host_if.rx_ready = 1'b1;
        tick();
        host_if.rx_ready = 1'b0;
    endtask

    task automatic wait_rd(input string name);
        int n = 0;
        while (!core_rd && n < 40) begin
            tick();
            n++;
        end
        check(name, core_rd, 1);
    endtask

    task automatic wait_wr(input string name);
        int n = 0;
        while (!core_wr && n < 40) begin
            tick();
            n++;
        end
        check(name, core_wr, 1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((wr_q.size() != 0 || rx_q.size() != 0) && n < 400) begin
            tick();
            n++;
        end
        check(name, wr_q.size() + rx_q.size(), 0);
    endtask

    typedef struct {
        logic [DW-1:0] din;
        logic [DW-1:0] dout;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        tbl[0] = '{din: 8'hAA, dout: 8'h55};
        tbl[1] = '{din: 8'h01, dout: 8'h02};
        tbl[2] = '{din: 8'h80, dout: 8'h01};
        tbl[3] = '{din: 8'h00, dout: 8'h00};
        tbl[4] = '{din: 8'hFF, dout: 8'hFF};
        tbl[5] = '{din: 8'h3C, dout: 8'h78};
        tbl[6] = '{din: 8'h81, dout: 8'h03};

        host_if.tx_valid = 1'b0;
        host_if.tx_data  = '0;
        host_if.rx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx_ready", host_if.tx_ready, 1);
        check("rst_rx_valid", host_if.rx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_strobes", {core_cs, core_wr, core_rd}, 0);
        rst = 1'b1;
        tick();

        // Single-byte transfers, table driven
        for (int i = 0; i < 7; i++) begin
            push(tbl[i].din);
            check("lat_wr_c1", core_wr, 0);
            check("busy_queued", busy, 1);
            tick();
            check("lat_wr_c2", core_wr, 1);
            check("single_din", core_din, tbl[i].din);
            wait_rd("single_rd");
            check("rx_valid_at_rd", host_if.rx_valid, 0);
            tick();
            check("rx_valid_after_rd", host_if.rx_valid, 1);
            check("single_rx", host_if.rx_data, tbl[i].dout);
            pop1();
            check("rx_valid_popped", host_if.rx_valid, 0);
            check("idle_busy", busy, 0);
        end

        // Burst of four with the core stalled, then released
        host_if.rx_ready = 1'b1;
        core_hold = 1'b1;
        push(8'h01);
        push(8'h02);
        push(8'h03);
        push(8'h04);
        check("burst_tx_full", host_if.tx_ready, 0);
        push(8'h99);
        check("burst_full_ignored", host_if.tx_ready, 0);
        check("burst_no_start", core_cs, 0);
        w0 = wr_pulses;
        core_hold = 1'b0;
        drain("burst_drain");
        check("burst_pulses", wr_pulses - w0, 4);
        host_if.rx_ready = 1'b0;
        tick();

        // RX backpressure: five bytes, only four transfers fit
        w0 = wr_pulses;
        for (int i = 0; i < 5; i++) push_wait(8'h10 + 8'(i));
        repeat (150) tick();
        check("bp_four_xfers", wr_pulses - w0, 4);
        check("bp_rx_valid", host_if.rx_valid, 1);
        check("bp_busy", busy, 1);
        check("bp_idle_cs", core_cs, 0);
        pop1();
        repeat (30) tick();
        check("bp_released", wr_pulses - w0, 5);
        host_if.rx_ready = 1'b1;
        drain("bp_drain");
        host_if.rx_ready = 1'b0;
        tick();

        // Simultaneous TX push and pop at count 2
        core_hold = 1'b1;
        push(8'h21);
        push(8'h22);
        check("sim_count_before", dut.u_tx_fifo.count_q, 2);
        core_hold = 1'b0;
        tick();
        check("sim_start", core_wr, 1);
        push(8'h23);
        check("sim_count_after", dut.u_tx_fifo.count_q, 2);
        host_if.rx_ready = 1'b1;
        drain("sim_drain");
        host_if.rx_ready = 1'b0;
        tick();

        // Reset asserted while waiting for the core to finish
        push(8'h31);
        wait_wr("rst_seq_wr");
        core_hold = 1'b1;
        push(8'h32);
        push(8'h33);
        repeat (4) tick();
        check("rst_seq_busy", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_strobes", {core_cs, core_wr, core_rd}, 0);
        check("midrst_tx_ready", host_if.tx_ready, 1);
        check("midrst_rx_valid", host_if.rx_valid, 0);
        check("midrst_busy", busy, 0);
        wr_q.delete();
        rx_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        core_hold = 1'b0;
        tick();
        push(8'h55);
        wait_rd("post_rst_rd");
        tick();
        check("post_rst_rx_valid", host_if.rx_valid, 1);
        check("post_rst_rx", host_if.rx_data, 8'hAA);
        host_if.rx_ready = 1'b1;
        drain("post_rst_drain");
        host_if.rx_ready = 1'b0;
        tick();
        check("final_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
